// File: rtl/vga_draw_scheduler_pkg.sv
// Shared state encoding and datapath-select constants for vga_draw_scheduler.
package draw_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic SEL_SELF  = 1'b0;
  localparam logic SEL_ENEMY = 1'b1;

endpackage

// File: rtl/vga_draw_scheduler_scan.sv
// pixel_scan_counter: x-major sprite scan; clear forces (0,0), enable advances
// one pixel and wraps back to (0,0) after the last pixel.
module pixel_scan_counter
  import draw_sched_pkg::*;
#(
  parameter int unsigned SPRITE_W = 4,
  parameter int unsigned SPRITE_H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] offset_x,
  output logic [3:0] offset_y,
  output logic       last
);

  localparam logic [3:0] X_MAX = 4'(SPRITE_W - 1);
  localparam logic [3:0] Y_MAX = 4'(SPRITE_H - 1);

  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  logic       x_wrap;
  logic       y_wrap;

  assign x_wrap = (x_q == X_MAX);
  assign y_wrap = (y_q == Y_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (enable) begin
      x_d = x_wrap ? '0 : x_q + 4'd1;
      if (x_wrap) begin
        y_d = y_wrap ? '0 : y_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign offset_x = x_q;
  assign offset_y = y_q;
  assign last     = x_wrap && y_wrap;

endmodule

// File: rtl/vga_draw_scheduler.sv
// Round-robin sprite draw scheduler for two datapaths (self / enemy).
// Optional macro VGA_DRAW_ERASE_EN adds an erase scan pass before each draw pass.
module vga_draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int unsigned SPRITE_W = 4,
  parameter int unsigned SPRITE_H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       req_self,
  input  logic       req_enemy,
  output logic       datapath_select,
  output logic       gnt_self,
  output logic       gnt_enemy,
  output logic [3:0] offset_x,
  output logic [3:0] offset_y,
  output logic       plot,
  output logic       erase,
  output logic       done_self,
  output logic       done_enemy,
  output logic       busy,
  output logic       frame_overrun
);

  state_e state_q, state_d;
  logic   sel_q, sel_d;
  logic   gnt_self_q, gnt_self_d;
  logic   gnt_enemy_q, gnt_enemy_d;
  logic   plot_q, plot_d;
  logic   done_self_q, done_self_d;
  logic   done_enemy_q, done_enemy_d;
  logic   busy_q, busy_d;
  logic   overrun_q, overrun_d;
  logic   served_self_q, served_self_d;
  logic   served_enemy_q, served_enemy_d;
  logic   last_served_q, last_served_d;

  logic   elig_self;
  logic   elig_enemy;
  logic   grant_sel;
  logic   scan_clear;
  logic   scan_en;
  logic   scan_last;
  logic   final_pass;

  assign elig_self  = req_self  && !served_self_q;
  assign elig_enemy = req_enemy && !served_enemy_q;
  // On a tie the requester that was not served last wins.
  assign grant_sel  = (elig_enemy && (!elig_self || last_served_q == SEL_SELF))
                      ? SEL_ENEMY : SEL_SELF;

  assign scan_clear = (state_q != ST_DRAW);
  assign scan_en    = (state_q == ST_DRAW);

  pixel_scan_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H)
  ) u_scan (
    .clk      (clk),
    .resetn   (resetn),
    .clear    (scan_clear),
    .enable   (scan_en),
    .offset_x (offset_x),
    .offset_y (offset_y),
    .last     (scan_last)
  );

`ifdef VGA_DRAW_ERASE_EN
  logic pass_q, pass_d;
  logic erase_q, erase_d;

  // pass 0 erases, pass 1 draws; the counter wraps to (0,0) between passes.
  always_comb begin
    pass_d = 1'b0;
    if (state_q == ST_DRAW) begin
      pass_d = scan_last ? ~pass_q : pass_q;
    end
    erase_d = (state_d == ST_DRAW) && !pass_d;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pass_q  <= 1'b0;
      erase_q <= 1'b0;
    end else begin
      pass_q  <= pass_d;
      erase_q <= erase_d;
    end
  end

  assign final_pass = pass_q;
  assign erase      = erase_q;
`else
  assign final_pass = 1'b1;
  assign erase      = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      sel_q          <= SEL_SELF;
      gnt_self_q     <= 1'b0;
      gnt_enemy_q    <= 1'b0;
      plot_q         <= 1'b0;
      done_self_q    <= 1'b0;
      done_enemy_q   <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
      served_self_q  <= 1'b0;
      served_enemy_q <= 1'b0;
      last_served_q  <= SEL_ENEMY;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      gnt_self_q     <= gnt_self_d;
      gnt_enemy_q    <= gnt_enemy_d;
      plot_q         <= plot_d;
      done_self_q    <= done_self_d;
      done_enemy_q   <= done_enemy_d;
      busy_q         <= busy_d;
      overrun_q      <= overrun_d;
      served_self_q  <= served_self_d;
      served_enemy_q <= served_enemy_d;
      last_served_q  <= last_served_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (elig_self || elig_enemy) state_d = ST_DRAW;
      ST_DRAW: if (scan_last && final_pass) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_d        = (state_q == ST_IDLE && state_d == ST_DRAW) ? grant_sel : sel_q;
    plot_d       = (state_d == ST_DRAW);
    gnt_self_d   = plot_d && (sel_d == SEL_SELF);
    gnt_enemy_d  = plot_d && (sel_d == SEL_ENEMY);
    busy_d       = (state_d != ST_IDLE);
    done_self_d  = (state_d == ST_DONE) && (sel_q == SEL_SELF);
    done_enemy_d = (state_d == ST_DONE) && (sel_q == SEL_ENEMY);
    overrun_d    = overrun_q || (frame_tick && (elig_self || elig_enemy));

    served_self_d  = served_self_q;
    served_enemy_d = served_enemy_q;
    last_served_d  = last_served_q;
    // Served is set while leaving DONE so a coincident frame_tick clear wins.
    if (state_q == ST_DONE) begin
      last_served_d = sel_q;
      if (sel_q == SEL_SELF) served_self_d  = 1'b1;
      else                   served_enemy_d = 1'b1;
    end
    if (frame_tick) begin
      served_self_d  = 1'b0;
      served_enemy_d = 1'b0;
    end
  end

  assign datapath_select = sel_q;
  assign gnt_self        = gnt_self_q;
  assign gnt_enemy       = gnt_enemy_q;
  assign plot            = plot_q;
  assign done_self       = done_self_q;
  assign done_enemy      = done_enemy_q;
  assign busy            = busy_q;
  assign frame_overrun   = overrun_q;

endmodule

// File: doc/vga_draw_scheduler.md
VGA_DRAW_SCHEDULER -- requirements
Module: vga_draw_scheduler

Interface
REQ-001 SHALL have parameter SPRITE_W, default 4, sprite width in pixels (legal 2..16).
REQ-002 SHALL have parameter SPRITE_H, default 4, sprite height in pixels (legal 2..16).
REQ-003 SHALL use one clock and an asynchronous, active-low reset; ports clk and resetn.
REQ-004 SHALL provide these ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-cycle pulse at the start of each frame.
- req_self  in  1  level request from the self datapath.
- req_enemy  in  1  level request from the enemy datapath.
- datapath_select  out  1  to the datapath mux; 0 = self, 1 = enemy.
- gnt_self, gnt_enemy  out  1 each  high for the whole burst of the granted requester.
- offset_x, offset_y  out  4 each  pixel offset within the sprite.
- plot  out  1  VGA write enable.
- erase  out  1  high while the erase pass is drawing.
- done_self, done_enemy  out  1 each  one-cycle pulse when a burst completes.
- busy  out  1  high when the state is not IDLE.
- frame_overrun  out  1  sticky flag for a missed draw.

Function
REQ-005 SHALL implement the states IDLE, DRAW and DONE, with all outputs registered.
REQ-006 A requester SHALL be eligible when its req is high and its served flag is 0.
REQ-007 In IDLE with at least one eligible requester, the next state SHALL be DRAW, with select and grant set and offsets 0.
REQ-008 When both requesters are eligible in the same cycle, the grant SHALL go to the one not served last (round-robin).
REQ-009 In DRAW, plot SHALL be 1 every cycle.
REQ-010 In DRAW, offset_x SHALL increment each cycle and wrap at SPRITE_W-1, and offset_y SHALL increment on each x wrap.
REQ-011 After the plot cycle at (SPRITE_W-1, SPRITE_H-1), the next state SHALL be DONE.
REQ-012 DONE SHALL last one cycle, with plot=0, grants low, the matching done_* pulsed, the served flag set and last_served updated; the next state SHALL be IDLE.
REQ-013 Latency SHALL be as follows: an eligible request sampled in IDLE at cycle N gives the first plot at N+1 and the done pulse at N+1+SPRITE_W*SPRITE_H.
REQ-014 datapath_select SHALL hold its last value in IDLE and DONE.
REQ-015 A request dropped during DRAW SHALL NOT abort the burst; the burst completes and done still pulses.
REQ-016 frame_tick SHALL clear both served flags and SHALL NOT abort DRAW.
REQ-017 When frame_tick coincides with DONE, the clear SHALL win over the set, so the requester may draw again this frame.
REQ-018 frame_overrun SHALL set when frame_tick arrives while any requester is eligible (its req high and not yet served this frame), and SHALL stay set until reset.
REQ-019 A request arriving during DRAW or DONE SHALL be arbitrated in the next IDLE cycle.

Reset
REQ-020 Reset SHALL put the block in IDLE with these values:
- plot, erase, gnt_*, done_*, busy, frame_overrun at 0.
- datapath_select and offsets at 0.
- served flags at 0.
- last_served = enemy, so self wins the first tie.
REQ-021 Reset asserted mid-burst SHALL force the reset values immediately, with no done pulse.

Configuration
REQ-022 Macro VGA_DRAW_ERASE_EN, when defined, SHALL make each burst two scan passes of SPRITE_W*SPRITE_H plot cycles each:
- the first pass with erase=1;
- the second pass with erase=0;
- done_* pulsing after the second pass, at N+1+2*SPRITE_W*SPRITE_H.
REQ-023 Without VGA_DRAW_ERASE_EN, the erase port SHALL be tied to 0 and a single pass per burst SHALL be used.

Structure
REQ-024 Package draw_sched_pkg SHALL hold the state enum and the constants SEL_SELF=1'b0 and SEL_ENEMY=1'b1.
REQ-025 The x/y scan SHALL be one sub-module, pixel_scan_counter, with inputs clear and enable and outputs offset_x, offset_y and a last flag.

Verification
REQ-026 The bench SHALL cover these scenarios (defaults 4x4, macro undefined):
- req_self only, at cycle 10 -> plot cycles 11..26, offsets (0,0)..(3,3) x-major, done_self at 27, select=0.
- req_self and req_enemy together after reset -> self burst first, then enemy burst starting 2 cycles after done_self, with select=1.
- Self served, req_self held, no frame_tick -> no second grant; after frame_tick -> granted again.
- req_enemy pending and unserved, then frame_tick -> frame_overrun=1 and it stays 1 until resetn.
- resetn low at the 5th plot cycle -> all outputs at reset values asynchronously, no done pulse.
- VGA_DRAW_ERASE_EN defined, req_enemy -> 16 plots with erase=1, then 16 plots with erase=0, then done_enemy.
